// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared definitions for the pipelined single-port SRAM:
//               controller state encoding, legal read-latency range and
//               geometry helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    // Controller state encoding (1 bit wide)
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Legal range of read latencies
    localparam int c_READ_LATENCY_MIN = 1;
    localparam int c_READ_LATENCY_MAX = 2;

    // Number of words addressable with addr_width bits
    function automatic int sram_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Number of byte lanes in a word of data_width bits
    function automatic int sram_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_array.sv
`default_nettype none
// ============================================================================
// Module      : sram_array
// Description : Storage array with one byte-enable write port and one
//               synchronous read port with a single-cycle registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_array
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int c_DEPTH = sram_depth(ADDR_WIDTH);
    localparam int c_LANES = sram_lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Byte-lane write: only enabled lanes of the addressed word change
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (wbe[i]) begin
                    r_mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register holds its value between reads; cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sram_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sram_pipe
// Description : Parametrised single-port SRAM with a valid/ready request
//               channel, valid-qualified read responses, byte-enable writes,
//               1- or 2-cycle read latency and an optional clear sweep after
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_pipe
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 11,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    init_done
);

    localparam int                    c_DEPTH = sram_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST  = ADDR_WIDTH'(c_DEPTH - 1);

    // Parameter legality is checked at elaboration
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("sram_pipe: DATA_WIDTH must be a multiple of 8");
    end

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic                  r_init_done;
    logic                  w_init_done_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;

    logic                    w_accept;
    logic                    w_init_we;
    logic                    w_we;
    logic                    w_re;
    logic [ADDR_WIDTH-1:0]   w_waddr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH/8-1:0] w_wbe;
    logic [DATA_WIDTH-1:0]   w_arr_rdata;
    logic                    r_vld1;

    // State and init-done registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    // Leave INIT after the last word is cleared, or immediately when no
    // clear is wanted
    always_comb begin
        w_state_nxt     = r_state;
        w_init_done_nxt = r_init_done;
        if (r_state == ST_INIT) begin
            if ((CLEAR_ON_RESET == 0) || (r_init_cnt == c_LAST)) begin
                w_state_nxt     = ST_RUN;
                w_init_done_nxt = 1'b1;
            end
        end
    end

    // Sweep address for the clear pass
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    // A request in the reset cycle is dropped, so ready is masked by rst
    assign req_ready = (r_state == ST_RUN) && !rst;
    assign init_done = r_init_done;
    assign w_accept  = req_valid && req_ready;
    assign w_init_we = (r_state == ST_INIT) && (CLEAR_ON_RESET != 0) && !rst;
    assign w_re      = w_accept && req_rw;

    // Write port is shared between the clear sweep and request writes
    always_comb begin
        w_we    = w_init_we || (w_accept && !req_rw);
        w_waddr = req_addr;
        w_wdata = req_wdata;
        w_wbe   = req_be;
        if (w_init_we) begin
            w_waddr = r_init_cnt;
            w_wdata = '0;
            w_wbe   = '1;
        end
    end

    sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .wbe   (w_wbe),
        .re    (w_re),
        .raddr (req_addr),
        .rdata (w_arr_rdata)
    );

    // First stage of the response-valid chain tracks the array read register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld1 <= 1'b0;
        end else begin
            r_vld1 <= w_re;
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign rsp_valid = r_vld1;
        assign rsp_rdata = w_arr_rdata;
    end else if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_vld2;
        logic [DATA_WIDTH-1:0] r_rdata_q;

        // Extra output stage, loaded only when a read result arrives so the
        // response holds its last value between reads
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld2    <= 1'b0;
                r_rdata_q <= '0;
            end else begin
                r_vld2 <= r_vld1;
                if (r_vld1) begin
                    r_rdata_q <= w_arr_rdata;
                end
            end
        end

        assign rsp_valid = r_vld2;
        assign rsp_rdata = r_rdata_q;
    end else begin : g_bad_latency
        $error("sram_pipe: READ_LATENCY must be between %0d and %0d",
               c_READ_LATENCY_MIN, c_READ_LATENCY_MAX);
        assign rsp_valid = 1'b0;
        assign rsp_rdata = '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_pipe
// Description : Self-checking bench for sram_pipe. Two instances share one
//               request stream: the default configuration (latency 1, clear
//               on reset) and latency 2 without clear. A queue-based model
//               predicts readiness, memory contents and response timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_rw;
    logic [10:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;

    logic [1:0]  rdy;
    logic [1:0]  vld;
    logic [1:0]  done;
    logic [15:0] rdata [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_pipe u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .rsp_valid(vld[0]), .rsp_rdata(rdata[0]),
        .init_done(done[0])
    );

    sram_pipe #(.READ_LATENCY(2), .CLEAR_ON_RESET(0)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .rsp_valid(vld[1]), .rsp_rdata(rdata[1]),
        .init_done(done[1])
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          d;
        int          due;
        logic [15:0] data;
        bit          known;
    } rsp_t;

    int          cyc = 0;
    int          rcnt [2] = '{0, 0};
    int          need [2] = '{2048, 1};
    int          lat  [2] = '{1, 2};
    logic [15:0] mm   [2][2048];
    bit   [1:0]  mk   [2][2048];
    rsp_t        pq[$];
    bit          e_valid [2];
    logic [15:0] e_last  [2];
    bit          e_known [2];

    task automatic model_edge();
        rsp_t r;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                rcnt[d]    = 0;
                e_last[d]  = '0;
                e_known[d] = 1'b1;
                for (int a = 0; a < 2048; a++) begin
                    mm[d][a] = '0;
                    mk[d][a] = (d == 0) ? 2'b11 : 2'b00;
                end
                for (int i = pq.size() - 1; i >= 0; i--) begin
                    if (pq[i].d == d) pq.delete(i);
                end
            end else begin
                if ((rcnt[d] >= need[d]) && req_valid) begin
                    if (req_rw) begin
                        r.d     = d;
                        r.due   = cyc + lat[d];
                        r.data  = mm[d][req_addr];
                        r.known = (mk[d][req_addr] == 2'b11);
                        pq.push_back(r);
                    end else begin
                        for (int b = 0; b < 2; b++) begin
                            if (req_be[b]) begin
                                mm[d][req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                                mk[d][req_addr][b]        = 1'b1;
                            end
                        end
                    end
                end
                if (rcnt[d] < 100000) rcnt[d]++;
            end
        end
        cyc++;
        for (int d = 0; d < 2; d++) begin
            e_valid[d] = 1'b0;
            for (int i = 0; i < pq.size(); i++) begin
                if (pq[i].d == d) begin
                    if (pq[i].due == cyc) begin
                        e_valid[d] = 1'b1;
                        e_last[d]  = pq[i].data;
                        e_known[d] = pq[i].known;
                        pq.delete(i);
                    end
                    break;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ready%0d@%0d", d, cyc), 32'(rdy[d]), 32'(rcnt[d] >= need[d]));
            chk($sformatf("init_done%0d@%0d", d, cyc), 32'(done[d]), 32'(rcnt[d] >= need[d]));
            chk($sformatf("rsp_valid%0d@%0d", d, cyc), 32'(vld[d]), 32'(e_valid[d]));
            if (e_known[d]) begin
                chk($sformatf("rsp_rdata%0d@%0d", d, cyc), 32'(rdata[d]), 32'(e_last[d]));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic rw, input logic [10:0] a,
                         input logic [15:0] wd, input logic [1:0] be);
        req_valid = v;
        req_rw    = rw;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 2048; a++) begin
                mm[d][a] = '0;
                mk[d][a] = 2'b00;
            end
            e_valid[d] = 1'b0;
            e_last[d]  = '0;
            e_known[d] = 1'b0;
        end
        rst = 1'b1;
        drive(1'b0, 1'b1, 11'h0, 16'h0, 2'b00);
        #1;
        step();
        step();
        chk("reset_ready0", 32'(rdy[0]), 32'd0);
        chk("reset_rsp_rdata0", 32'(rdata[0]), 32'h0);
        rst = 1'b0;

        // Hold read requests through the clear sweep
        for (int i = 0; i < 2048; i++) begin
            drive(1'b1, 1'b1, 11'($urandom), 16'h0, 2'b00);
            step();
            if (i == 2046) chk("ready0_before_2048", 32'(rdy[0]), 32'd0);
        end
        chk("ready0_at_2048", 32'(rdy[0]), 32'd1);
        chk("init_done0_at_2048", 32'(done[0]), 32'd1);

        drive(1'b1, 1'b1, 11'h7FF, 16'h0, 2'b00);
        step();
        chk("rd7ff_valid", 32'(vld[0]), 32'd1);
        chk("rd7ff_data", 32'(rdata[0]), 32'h0000);

        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b0, 11'(i), 16'(i), 2'b11);
            step();
        end
        drive(1'b1, 1'b1, 11'h005, 16'h0, 2'b00);
        step();
        chk("rd5_data", 32'(rdata[0]), 32'h0005);
        drive(1'b1, 1'b1, 11'h00A, 16'h0, 2'b00);
        step();
        chk("rdA_data", 32'(rdata[0]), 32'h000A);

        drive(1'b1, 1'b0, 11'h200, 16'hAAAA, 2'b11);
        step();
        drive(1'b1, 1'b1, 11'h200, 16'h0, 2'b00);
        step();
        chk("wr_rd_b2b", 32'(rdata[0]), 32'hAAAA);
        drive(1'b1, 1'b0, 11'h200, 16'h5555, 2'b01);
        step();
        drive(1'b1, 1'b1, 11'h200, 16'h0, 2'b00);
        step();
        chk("be01_merge", 32'(rdata[0]), 32'hAA55);
        drive(1'b1, 1'b0, 11'h200, 16'hFFFF, 2'b00);
        step();
        drive(1'b1, 1'b1, 11'h200, 16'h0, 2'b00);
        step();
        chk("be00_noop", 32'(rdata[0]), 32'hAA55);

        // Latency-2 back-to-back reads on the second instance
        drive(1'b0, 1'b1, 11'h0, 16'h0, 2'b00);
        step();
        step();
        drive(1'b1, 1'b1, 11'h005, 16'h0, 2'b00);
        step();
        chk("lat2_not_yet", 32'(vld[1]), 32'd0);
        drive(1'b1, 1'b1, 11'h006, 16'h0, 2'b00);
        step();
        chk("lat2_v5", 32'(vld[1]), 32'd1);
        chk("lat2_d5", 32'(rdata[1]), 32'h0005);
        drive(1'b1, 1'b1, 11'h007, 16'h0, 2'b00);
        step();
        chk("lat2_d6", 32'(rdata[1]), 32'h0006);
        drive(1'b0, 1'b1, 11'h0, 16'h0, 2'b00);
        step();
        chk("lat2_d7", 32'(rdata[1]), 32'h0007);
        step();
        chk("lat2_low", 32'(vld[1]), 32'd0);

        // Randomised traffic over a small address window
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 1'($urandom), 11'($urandom_range(0, 31)),
                  16'($urandom), 2'($urandom));
            step();
        end

        // Reset with a read in flight
        drive(1'b0, 1'b1, 11'h0, 16'h0, 2'b00);
        step();
        step();
        drive(1'b1, 1'b1, 11'h005, 16'h0, 2'b00);
        step();
        drive(1'b1, 1'b0, 11'h005, 16'hFFFF, 2'b11);
        rst = 1'b1;
        step();
        chk("inflight_dropped1", 32'(vld[1]), 32'd0);
        step();
        chk("inflight_dropped1b", 32'(vld[1]), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b1, 11'h0, 16'h0, 2'b00);
        step();
        chk("noclear_ready1", 32'(rdy[1]), 32'd1);
        chk("noclear_done1", 32'(done[1]), 32'd1);
        for (int i = 1; i < 2048; i++) step();
        chk("reinit_ready0", 32'(rdy[0]), 32'd1);
        drive(1'b1, 1'b1, 11'h005, 16'h0, 2'b00);
        step();
        chk("reinit_rd5", 32'(rdata[0]), 32'h0000);
        drive(1'b0, 1'b1, 11'h0, 16'h0, 2'b00);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_pipe.md
Name: sram_pipe

Overview:
- Parametrised single-port synchronous SRAM and the successor to the fixed 2K x 16 sram.
- Replaces the cs/oe/rw tri-state bus with a valid/ready request channel and a valid-qualified read-response channel.
- Adds byte-enable writes, a configurable read pipeline depth, and a hardware clear-on-reset sweep.
- Sits between the datapath/memory-stage logic and on-chip storage.

Parameters:
- DATA_WIDTH, 16: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 11: address bits; DEPTH = 2**ADDR_WIDTH words.
- READ_LATENCY, 1: cycles from read acceptance to response; legal values 1 or 2.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = skip the clear, contents undefined.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_rw  input  1  1 = read, 0 = write (same polarity as legacy rw).
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  write data.
- req_be  input  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  output  1  read data valid, one-cycle pulse per read.
- rsp_rdata  output  DATA_WIDTH  read data; holds its last value when rsp_valid is 0.
- init_done  output  1  clear sweep complete; stays high until the next rst.

Behaviour:
- Reset (rst high at an edge):
  - state <= ST_INIT, init_cnt <= 0.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, init_done = 0.
  - All in-flight reads in the pipeline are discarded.
  - Reset mid-operation behaves identically: no response is ever produced for a read accepted before rst.
- ST_INIT, CLEAR_ON_RESET = 1:
  - Each cycle writes 0 to mem[init_cnt], then init_cnt++.
  - On the cycle that writes DEPTH-1: next state ST_RUN, init_done <= 1.
  - First req_ready = 1 is DEPTH cycles after the first cycle with rst low. Default config: 2048.
  - req_valid is ignored during ST_INIT.
- ST_INIT, CLEAR_ON_RESET = 0:
  - Moves to ST_RUN one cycle after rst is released; init_done goes high on that same transition.
- ST_RUN:
  - req_ready = 1 every cycle. No response backpressure; the consumer must always sink rsp.
  - A request is accepted when req_valid && req_ready at an edge.
- Write accepted at cycle t:
  - For each i with req_be[i] = 1, mem[addr] byte i <= req_wdata byte i. Other bytes unchanged.
  - be = 0 is a legal no-op.
  - Writes produce no response.
  - The written value is visible to any read accepted at t+1 or later; back-to-back write-then-read to the same address must return the new data.
- Read accepted at cycle t:
  - rsp_valid = 1 and rsp_rdata = mem[addr] in cycle t+READ_LATENCY.
  - Reads are fully pipelined: one accepted per cycle gives one response per cycle, in order.
- Only one request per cycle, so there is no read/write collision within a cycle.
- Address space is exactly DEPTH; no out-of-range case.
- Simultaneous rst and req_valid: rst wins, the request is dropped.
- Illegal READ_LATENCY or DATA_WIDTH%8 != 0 is an elaboration error.

Decomposition:
- Shared package sram_pkg holds:
  - state encoding ST_INIT, ST_RUN (1-bit).
  - constants for the legal READ_LATENCY range.
  - the function computing DEPTH and the byte-lane count.
- One sub-module, sram_array:
  - storage with a byte-enable write port and a synchronous 1-cycle read port.
  - sram_pipe wraps it with the FSM, init counter, write mux (init vs. request) and the optional second read-pipeline register plus valid shift chain.

Test Plan:
- rst 2 cycles, then hold req_valid -> req_ready/init_done rise exactly 2048 cycles after rst falls; read 0x7FF -> rsp_rdata 0x0000 one cycle later.
- Write addr 1..16 with data 1..16, be=11 -> read addr 5 returns 0x0005 at t+1; read 0xA returns 0x000A.
- Write 0x200=0xAAAA, read 0x200 in the very next cycle -> 0xAAAA.
- Write 0x200=0x5555 with be=01 -> reads 0xAA55; then be=00 write 0xFFFF -> still 0xAA55.
- READ_LATENCY=2: reads to 5, 6, 7 accepted at t, t+1, t+2 -> rsp_valid high t+2..t+4 with 0x0005, 0x0006, 0x0007; low at t+5.
- Accept read of 5, assert rst next cycle -> rsp_valid never rises; after re-init, addr 5 reads 0x0000. CLEAR_ON_RESET=0 -> req_ready high one cycle after rst falls.
